mdu_hilo: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file read ports.
- Consumes the two read-data operands (rs → op_a, rt → op_b) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Holds results in HI/LO for later MFHI/MFLO forwarding to the write-back port of the register file.

---
 rtl/mdu_hilo.sv | 188 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             is_md, is_signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign is_md        = ~op[2];
    assign is_signed_op = ~op[0];
    assign a_neg        = is_signed_op & op_a[WIDTH-1];
    assign b_neg        = is_signed_op & op_b[WIDTH-1];
    assign mag_a        = a_neg ? (~op_a + 1'b1) : op_a;
    assign mag_b        = b_neg ? (~op_b + 1'b1) : op_b;

    // Multiply: acc_hi holds the running upper half, acc_lo shifts the multiplier out.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign quot_fix = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    assign rem_fix  = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        raw_a_d    = raw_a_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_md) begin
                        state_d    = S_CALC;
                        cnt_d      = '0;
                        is_div_d   = op[1];
                        neg_d      = a_neg ^ b_neg;
                        rem_neg_d  = a_neg;
                        div_zero_d = op[1] & (op_b == '0);
                        raw_a_d    = op_a;
                        acc_hi_d   = '0;
                        opnd_d     = op[1] ? mag_b : mag_a;
                        acc_lo_d   = op[1] ? mag_a : mag_b;
                        busy_d     = 1'b1;
                    end else if (op[1:0] == 2'b00) begin
                        hi_d = op_a;
                    end else if (op[1:0] == 2'b01) begin
                        lo_d = op_a;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div_zero_q) begin
                        // Sign rules would flip an all-ones quotient for a negative dividend.
                        hi_d = raw_a_q;
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            raw_a_q    <= raw_a_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - randomized self-checking bench for mdu_hilo against an arithmetic model
module tb_mdu_hilo;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mdu_hilo #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] mh, output logic [31:0] ml);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mh = '0;
        ml = '0;
        case (o)
            OP_MULT: begin
                p = 64'(sa * sb);
                mh = p[63:32]; ml = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                mh = p[63:32]; ml = p[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    mh = a; ml = 32'hFFFFFFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    mh = 32'(r); ml = 32'(q);
                end
            end
            OP_DIVU: begin
                if (b == 0) begin
                    mh = a; ml = 32'hFFFFFFFF;
                end else begin
                    mh = a % b; ml = a / b;
                end
            end
            default: ;
        endcase
    endtask

    // Issues one MULT/DIV at #1 after an edge; returns #1 after the edge where done rises.
    task automatic mdop(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inj, input string tag);
        logic [31:0] eh, el;
        int n, bc;
        model(o, a, b, eh, el);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = OP_MULT; op_a = $urandom; op_b = $urandom;
        n = 0; bc = 0;
        while (!done && n < 60) begin
            if (busy) bc++;
            if (inj && n == 4) begin
                start = 1'b1; op = OP_MTLO; op_a = ~exp_lo;
            end
            if (inj && n == 5) begin
                chk({tag, " mtlo_while_busy"}, 64'(lo), 64'(exp_lo));
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(W + 1));
        chk({tag, " busy_cycles"}, 64'(bc), 64'(W + 1));
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        exp_hi = eh;
        exp_lo = el;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dc;
        #1;
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        mdop(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, "multu_max");
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        mdop(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, "mult_neg");
        mdop(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
        mdop(OP_DIVU, 32'h12345678, 32'd0, 1'b0, "divu_zero");
        mdop(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        mdop(OP_DIV, 32'hFFFFFFF0, 32'd0, 1'b0, "div_zero_neg");

        @(posedge clk); #1;
        start = 1'b1; op = OP_MTHI; op_a = 32'hA5A5A5A5;
        @(posedge clk); #1;
        start = 1'b0;
        exp_hi = 32'hA5A5A5A5;
        chk("mthi hi", 64'(hi), 64'(exp_hi));
        chk("mthi busy", 64'(busy), 64'd0);
        chk("mthi done", 64'(done), 64'd0);
        mdop(OP_DIVU, 32'd1000, 32'd3, 1'b1, "mtlo_busy");

        // flush a MULT mid-flight; start and flush together in IDLE must still start
        start = 1'b1; op = OP_MULT; op_a = 32'h1234; op_b = 32'h5678; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_start busy", 64'(busy), 64'd1);
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush done", 64'(done), 64'd0);
        dc = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        chk("flush no_done", 64'(dc), 64'd0);
        chk("flush hi", 64'(hi), 64'(exp_hi));
        chk("flush lo", 64'(lo), 64'(exp_lo));
        mdop(OP_MULTU, 32'hDEADBEEF, 32'h12345, 1'b0, "after_flush");

        start = 1'b1; op = OP_DIVU; op_a = 32'hFFFF0000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        chk("async_rst hi", 64'(hi), 64'd0);
        chk("async_rst lo", 64'(lo), 64'd0);
        chk("async_rst busy", 64'(busy), 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        mdop(OP_DIVU, 32'd100, 32'd7, 1'b0, "divu_after_rst");

        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 3));
            mdop(ro, pick(), pick(), 1'b0, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
